// File: rtl/riscv_lsu_if.sv
// rtl/riscv_lsu_if.sv - core request/response and data-memory signals of the load/store unit
interface riscv_lsu_if #(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_DMEM_ADDR_WIDTH = 8
);
  logic                         i_req_valid;
  logic                         i_req_we;
  logic [2:0]                   i_req_funct3;
  logic [31:0]                  i_req_addr;
  logic [P_DATA_WIDTH-1:0]      i_req_wdata;
  logic [4:0]                   i_req_rd;
  logic                         o_busy;
  logic                         o_rsp_valid;
  logic [P_DATA_WIDTH-1:0]      o_rsp_rdata;
  logic [4:0]                   o_rsp_rd;
  logic                         o_misaligned;
  logic                         o_timeout;
  logic                         o_dmem_req;
  logic                         o_dmem_we;
  logic [P_DATA_WIDTH/8-1:0]    o_dmem_be;
  logic [P_DMEM_ADDR_WIDTH-1:0] o_dmem_addr;
  logic [P_DATA_WIDTH-1:0]      o_dmem_wdata;
  logic                         i_dmem_ready;
  logic [P_DATA_WIDTH-1:0]      i_dmem_rdata;

  modport slave (
    input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_req_rd,
    input  i_dmem_ready, i_dmem_rdata,
    output o_busy, o_rsp_valid, o_rsp_rdata, o_rsp_rd, o_misaligned, o_timeout,
    output o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata
  );

  modport master (
    output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_req_rd,
    output i_dmem_ready, i_dmem_rdata,
    input  o_busy, o_rsp_valid, o_rsp_rdata, o_rsp_rd, o_misaligned, o_timeout,
    input  o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata
  );
endinterface

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - RV32 load/store unit with handshaked variable-latency data-memory port
module riscv_lsu #(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_DMEM_ADDR_WIDTH = 8,
  parameter int P_TIMEOUT         = 255
) (
  input logic        i_clk,
  input logic        i_rst_n,
  riscv_lsu_if.slave bus
);
  localparam int LP_CW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT + 1) : 1;

  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e                       state_q, state_d;
  logic [LP_CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                   funct3_q, funct3_d;
  logic [1:0]                   off_q, off_d;
  logic [4:0]                   rd_q, rd_d;
  logic                         dmem_req_q, dmem_req_d;
  logic                         dmem_we_q, dmem_we_d;
  logic [3:0]                   dmem_be_q, dmem_be_d;
  logic [P_DMEM_ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [P_DATA_WIDTH-1:0]      dmem_wdata_q, dmem_wdata_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic [P_DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic [4:0]                   rsp_rd_q, rsp_rd_d;
  logic                         misaligned_q, misaligned_d;
  logic                         timeout_q, timeout_d;

  logic                         req_illegal;
  logic                         req_misal;
  logic [1:0]                   req_off;
  logic [3:0]                   req_be;
  logic [P_DATA_WIDTH-1:0]      req_wdata;
  logic                         unused_addr_hi;

  assign unused_addr_hi = ^bus.i_req_addr[31:P_DMEM_ADDR_WIDTH+2];

  // Lane select then extend; for word accesses the offset is always zero.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'b0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  always_comb begin
    req_off = bus.i_req_addr[1:0];
    if (bus.i_req_we) begin
      req_illegal = (bus.i_req_funct3 > 3'd2);
    end else begin
      req_illegal = (bus.i_req_funct3[1:0] == 2'b11) || (bus.i_req_funct3 == 3'b110);
    end
    req_misal = ((bus.i_req_funct3[1:0] == 2'b01) && req_off[0]) ||
                ((bus.i_req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
    case (bus.i_req_funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << req_off;
        req_wdata = {4{bus.i_req_wdata[7:0]}};
      end
      2'b01: begin
        req_be    = req_off[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{bus.i_req_wdata[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = bus.i_req_wdata;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_be_d    = dmem_be_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    rsp_rd_d     = 5'd0;
    misaligned_d = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_req_valid) begin
          if (req_illegal || req_misal) begin
            rsp_valid_d  = 1'b1;
            misaligned_d = 1'b1;
          end else begin
            state_d      = S_REQ;
            cnt_d        = '0;
            funct3_d     = bus.i_req_funct3;
            off_d        = req_off;
            rd_d         = bus.i_req_rd;
            dmem_req_d   = 1'b1;
            dmem_we_d    = bus.i_req_we;
            dmem_be_d    = req_be;
            dmem_addr_d  = bus.i_req_addr[P_DMEM_ADDR_WIDTH+1:2];
            dmem_wdata_d = req_wdata;
          end
        end
      end
      S_REQ: begin
        // Ready is checked first so a completion in the last allowed cycle is not a timeout.
        if (bus.i_dmem_ready) begin
          state_d     = S_IDLE;
          dmem_req_d  = 1'b0;
          rsp_valid_d = 1'b1;
          if (!dmem_we_q) begin
            rsp_rdata_d = load_ext(funct3_q, off_q, bus.i_dmem_rdata);
            rsp_rd_d    = rd_q;
          end
        end else if ((P_TIMEOUT != 0) && (cnt_q == LP_CW'(P_TIMEOUT - 1))) begin
          state_d     = S_IDLE;
          dmem_req_d  = 1'b0;
          rsp_valid_d = 1'b1;
          timeout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + LP_CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      rd_q         <= 5'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_be_q    <= 4'd0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_rd_q     <= 5'd0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_be_q    <= dmem_be_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_rd_q     <= rsp_rd_d;
      misaligned_q <= misaligned_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.o_busy       = (state_q == S_REQ);
  assign bus.o_rsp_valid  = rsp_valid_q;
  assign bus.o_rsp_rdata  = rsp_rdata_q;
  assign bus.o_rsp_rd     = rsp_rd_q;
  assign bus.o_misaligned = misaligned_q;
  assign bus.o_timeout    = timeout_q;
  assign bus.o_dmem_req   = dmem_req_q;
  assign bus.o_dmem_we    = dmem_we_q;
  assign bus.o_dmem_be    = dmem_be_q;
  assign bus.o_dmem_addr  = dmem_addr_q;
  assign bus.o_dmem_wdata = dmem_wdata_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - randomized self-checking bench for riscv_lsu against a byte-level memory model
module tb_riscv_lsu;
  localparam int TO = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  riscv_lsu_if #(.P_DATA_WIDTH(32), .P_DMEM_ADDR_WIDTH(8)) bus ();

  riscv_lsu #(.P_DATA_WIDTH(32), .P_DMEM_ADDR_WIDTH(8), .P_TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_req_valid  = 1'b0;
    bus.i_req_we     = 1'($urandom);
    bus.i_req_funct3 = 3'($urandom);
    bus.i_req_addr   = $urandom;
    bus.i_req_wdata  = $urandom;
    bus.i_req_rd     = 5'($urandom);
    bus.i_dmem_ready = 1'b0;
    bus.i_dmem_rdata = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dmem_req"},   32'(bus.o_dmem_req),   32'd0);
    check({tag, "_dmem_we"},    32'(bus.o_dmem_we),    32'd0);
    check({tag, "_dmem_be"},    32'(bus.o_dmem_be),    32'd0);
    check({tag, "_dmem_addr"},  32'(bus.o_dmem_addr),  32'd0);
    check({tag, "_dmem_wdata"}, bus.o_dmem_wdata,      32'd0);
    check({tag, "_rsp_valid"},  32'(bus.o_rsp_valid),  32'd0);
    check({tag, "_rsp_rdata"},  bus.o_rsp_rdata,       32'd0);
    check({tag, "_rsp_rd"},     32'(bus.o_rsp_rd),     32'd0);
    check({tag, "_misaligned"}, 32'(bus.o_misaligned), 32'd0);
    check({tag, "_timeout"},    32'(bus.o_timeout),    32'd0);
    check({tag, "_busy"},       32'(bus.o_busy),       32'd0);
  endtask

  // Called away from a rising edge; returns at the falling edge of the response cycle.
  // w = extra wait cycles before ready (ready in REQ cycle w+1).
  task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input int w);
    int          size, off, idx;
    bit          legal, sgn, fault, to;
    longint      val;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rdata;
    logic [4:0]  exp_rd;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    off   = int'(addr[1:0]);
    idx   = int'((addr >> 2) % 256);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sgn   = !f3[2];
    fault = !legal || (size == 0) || ((off % size) != 0);

    bus.i_req_valid  = 1'b1;
    bus.i_req_we     = we;
    bus.i_req_funct3 = f3;
    bus.i_req_addr   = addr;
    bus.i_req_wdata  = wd;
    bus.i_req_rd     = rd;
    bus.i_dmem_ready = 1'($urandom);
    @(posedge clk); #1;
    if (fault) begin
      idle_inputs();
      @(negedge clk);
      check("flt_rsp_valid",  32'(bus.o_rsp_valid),  32'd1);
      check("flt_misaligned", 32'(bus.o_misaligned), 32'd1);
      check("flt_timeout",    32'(bus.o_timeout),    32'd0);
      check("flt_rdata",      bus.o_rsp_rdata,       32'd0);
      check("flt_rd",         32'(bus.o_rsp_rd),     32'd0);
      check("flt_dmem_req",   32'(bus.o_dmem_req),   32'd0);
      check("flt_busy",       32'(bus.o_busy),       32'd0);
      return;
    end

    exp_be = 4'(((1 << size) - 1) << off);
    exp_wd = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
    to     = (w + 1 > TO);
    val    = 0;
    for (int i = 0; i < size; i++) val = val | (longint'(mem[idx][8*(off+i) +: 8]) << (8*i));
    if (sgn && size < 4 && val[8*size-1]) val = val - (longint'(1) << (8*size));
    exp_rdata = (to || we) ? 32'd0 : val[31:0];
    exp_rd    = (to || we) ? 5'd0 : rd;

    for (int k = 1; k <= TO; k++) begin
      bit rdy;
      rdy = (k == w + 1);
      bus.i_req_valid  = 1'($urandom);
      bus.i_req_we     = 1'($urandom);
      bus.i_req_funct3 = 3'($urandom);
      bus.i_req_addr   = $urandom;
      bus.i_req_wdata  = $urandom;
      bus.i_dmem_ready = rdy;
      bus.i_dmem_rdata = rdy ? mem[idx] : $urandom;
      @(negedge clk);
      if (k == 1) check("req_rsp_quiet", 32'(bus.o_rsp_valid), 32'd0);
      check("req_dmem_req", 32'(bus.o_dmem_req), 32'd1);
      check("req_busy",     32'(bus.o_busy),     32'd1);
      check("req_we",       32'(bus.o_dmem_we),  32'(we));
      check("req_be",       32'(bus.o_dmem_be),  32'(exp_be));
      check("req_addr",     32'(bus.o_dmem_addr), 32'(idx));
      check("req_wdata",    bus.o_dmem_wdata,    exp_wd);
      if (rdy) break;
      if (k < TO) begin
        @(posedge clk); #1;
      end
    end
    if (!to && we) begin
      for (int i = 0; i < size; i++) mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("rsp_valid",      32'(bus.o_rsp_valid),  32'd1);
    check("rsp_misaligned", 32'(bus.o_misaligned), 32'd0);
    check("rsp_timeout",    32'(bus.o_timeout),    32'(to));
    check("rsp_rdata",      bus.o_rsp_rdata,       exp_rdata);
    check("rsp_rd",         32'(bus.o_rsp_rd),     32'(exp_rd));
    check("rsp_dmem_req",   32'(bus.o_dmem_req),   32'd0);
    check("rsp_busy",       32'(bus.o_busy),       32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time-limit expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 0);
    access(1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 0);
    access(1'b1, 3'b010, 32'h10, 32'h80FF7F01, 5'd0, 1);
    access(1'b0, 3'b000, 32'h13, 32'h0, 5'd1, 0);
    access(1'b0, 3'b100, 32'h13, 32'h0, 5'd2, 0);
    access(1'b0, 3'b001, 32'h12, 32'h0, 5'd3, 0);
    access(1'b0, 3'b101, 32'h10, 32'h0, 5'd4, 0);
    access(1'b1, 3'b000, 32'h11, 32'h000000AB, 5'd0, 0);
    access(1'b0, 3'b010, 32'h10, 32'h0, 5'd6, 4);
    access(1'b0, 3'b010, 32'h12, 32'h0, 5'd7, 0);
    access(1'b0, 3'b011, 32'h10, 32'h0, 5'd8, 0);
    access(1'b1, 3'b100, 32'h10, 32'h0, 5'd8, 0);
    access(1'b0, 3'b010, 32'h14, 32'h0, 5'd9, 1000);
    access(1'b1, 3'b001, 32'h16, 32'h1234, 5'd0, 1000);
    access(1'b0, 3'b010, 32'h14, 32'h0, 5'd10, TO - 1);

    bus.i_req_valid  = 1'b1;
    bus.i_req_we     = 1'b0;
    bus.i_req_funct3 = 3'b010;
    bus.i_req_addr   = 32'h20;
    bus.i_req_rd     = 5'd9;
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_pre_busy", 32'(bus.o_busy), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    bus.i_dmem_ready = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("rst_no_rsp",  32'(bus.o_rsp_valid), 32'd0);
    check("rst_no_req",  32'(bus.o_dmem_req),  32'd0);
    access(1'b0, 3'b010, 32'h400, 32'h0, 5'd11, 2);

    for (int n = 0; n < 80; n++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      access(1'($urandom), 3'($urandom), a, $urandom, 5'($urandom), $urandom_range(0, TO + 1));
    end

    @(posedge clk); #1;
    @(negedge clk);
    check("final_pulse", 32'(bus.o_rsp_valid), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
